// File: rtl/pipe_mips32.sv
// Five-stage pipelined MIPS32-subset core (IF/ID/EX/MEM/WB) with a unified
// word-addressed memory, EX-stage operand forwarding and EX-resolved branches.
module pipe_mips32 #(
  parameter int MEM_DEPTH = 1024
) (
  input logic clk1,
  input logic rst
);
  localparam int AW = $clog2(MEM_DEPTH);

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {
    K_NOP, K_RR, K_RI, K_LOAD, K_STORE, K_BRANCH, K_HALT
  } kind_t;

  logic [31:0] Reg [0:31];
  logic [31:0] Mem [0:MEM_DEPTH-1];
  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;
  logic        halt_fetch;

  logic        if_id_valid;
  logic [31:0] if_id_ir, if_id_npc;

  kind_t       id_ex_kind;
  logic [5:0]  id_ex_op;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_dest;
  logic [31:0] id_ex_a, id_ex_b, id_ex_imm, id_ex_npc;

  kind_t       ex_mem_kind;
  logic [4:0]  ex_mem_dest;
  logic [31:0] ex_mem_alu, ex_mem_b;

  kind_t       mem_wb_kind;
  logic [4:0]  mem_wb_dest;
  logic [31:0] mem_wb_alu, mem_wb_lmd;

  function automatic logic writes_reg(kind_t k);
    return (k == K_RR) || (k == K_RI) || (k == K_LOAD);
  endfunction

  // ---------------- ID: decode and register read ----------------
  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt, id_rd, id_dest;
  logic [31:0] id_imm, id_a, id_b, wb_value;
  kind_t       id_kind;
  logic        wb_we;

  assign id_op    = if_id_ir[31:26];
  assign id_rs    = if_id_ir[25:21];
  assign id_rt    = if_id_ir[20:16];
  assign id_rd    = if_id_ir[15:11];
  assign id_imm   = {{16{if_id_ir[15]}}, if_id_ir[15:0]};
  assign wb_value = (mem_wb_kind == K_LOAD) ? mem_wb_lmd : mem_wb_alu;
  assign wb_we    = writes_reg(mem_wb_kind) && (mem_wb_dest != 5'd0) && !HALTED;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    id_kind = K_NOP;
    id_dest = id_rt;
    if (if_id_valid) begin
      case (id_op)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
          id_kind = K_RR;
          id_dest = id_rd;
        end
        OP_ADDI, OP_SUBI, OP_SLTI: id_kind = K_RI;
        OP_LW:                     id_kind = K_LOAD;
        OP_SW:                     id_kind = K_STORE;
        OP_BNEQZ, OP_BEQZ:         id_kind = K_BRANCH;
        OP_HLT:                    id_kind = K_HALT;
        default:                   id_kind = K_NOP;
      endcase
    end
  end

  // Write-before-read: a register retiring in WB this cycle is seen by ID.
  always_comb begin
    id_a = Reg[id_rs];
    id_b = Reg[id_rt];
    if (id_rs == 5'd0) id_a = '0;
    else if (wb_we && mem_wb_dest == id_rs) id_a = wb_value;
    if (id_rt == 5'd0) id_b = '0;
    else if (wb_we && mem_wb_dest == id_rt) id_b = wb_value;
  end

  // ---------------- EX: forwarding, ALU, branch ----------------
  logic        ex_mem_fwd, mem_wb_fwd, cond;
  logic [31:0] op_a, op_b, alu_out, br_target;

  assign ex_mem_fwd = writes_reg(ex_mem_kind) && (ex_mem_dest != 5'd0);
  assign mem_wb_fwd = writes_reg(mem_wb_kind) && (mem_wb_dest != 5'd0);

  always_comb begin
    op_a = id_ex_a;
    op_b = id_ex_b;
    if (id_ex_rs != 5'd0 && ex_mem_fwd && ex_mem_dest == id_ex_rs)      op_a = ex_mem_alu;
    else if (id_ex_rs != 5'd0 && mem_wb_fwd && mem_wb_dest == id_ex_rs) op_a = wb_value;
    if (id_ex_rt != 5'd0 && ex_mem_fwd && ex_mem_dest == id_ex_rt)      op_b = ex_mem_alu;
    else if (id_ex_rt != 5'd0 && mem_wb_fwd && mem_wb_dest == id_ex_rt) op_b = wb_value;
  end

  always_comb begin
    alu_out = '0;
    case (id_ex_kind)
      K_RR: begin
        case (id_ex_op)
          OP_ADD:  alu_out = op_a + op_b;
          OP_SUB:  alu_out = op_a - op_b;
          OP_AND:  alu_out = op_a & op_b;
          OP_OR:   alu_out = op_a | op_b;
          OP_SLT:  alu_out = {31'd0, $signed(op_a) < $signed(op_b)};
          default: alu_out = op_a * op_b;
        endcase
      end
      K_RI: begin
        case (id_ex_op)
          OP_ADDI: alu_out = op_a + id_ex_imm;
          OP_SUBI: alu_out = op_a - id_ex_imm;
          default: alu_out = {31'd0, $signed(op_a) < $signed(id_ex_imm)};
        endcase
      end
      K_LOAD, K_STORE: alu_out = op_a + id_ex_imm;
      default:         alu_out = '0;
    endcase
  end

  assign cond         = (id_ex_op == OP_BNEQZ) ? (op_a != 32'd0) : (op_a == 32'd0);
  assign br_target    = id_ex_npc + id_ex_imm;
  assign TAKEN_BRANCH = (id_ex_kind == K_BRANCH) && cond && !HALTED;

  // ---------------- Control state (reset to an empty pipeline) ----------------
  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk1) begin
    if (rst) begin
      PC          <= '0;
      HALTED      <= 1'b0;
      halt_fetch  <= 1'b0;
      if_id_valid <= 1'b0;
      id_ex_kind  <= K_NOP;
      ex_mem_kind <= K_NOP;
      mem_wb_kind <= K_NOP;
    end else if (!HALTED) begin
      if (TAKEN_BRANCH) begin
        PC          <= br_target;
        if_id_valid <= 1'b0;
      end else if (halt_fetch || id_kind == K_HALT) begin
        if_id_valid <= 1'b0;
      end else begin
        PC          <= PC + 32'd1;
        if_id_valid <= 1'b1;
      end
      if (!TAKEN_BRANCH && id_kind == K_HALT) halt_fetch <= 1'b1;
      id_ex_kind  <= TAKEN_BRANCH ? K_NOP : id_kind;
      ex_mem_kind <= id_ex_kind;
      mem_wb_kind <= ex_mem_kind;
      if (mem_wb_kind == K_HALT) HALTED <= 1'b1;
    end
  end

  // Datapath payload is qualified by the stage kinds, so it needs no reset.
  always_ff @(posedge clk1) begin
    if (!HALTED) begin
      if_id_ir    <= Mem[PC[AW-1:0]];
      if_id_npc   <= PC + 32'd1;
      id_ex_op    <= id_op;
      id_ex_rs    <= id_rs;
      id_ex_rt    <= id_rt;
      id_ex_dest  <= id_dest;
      id_ex_a     <= id_a;
      id_ex_b     <= id_b;
      id_ex_imm   <= id_imm;
      id_ex_npc   <= if_id_npc;
      ex_mem_dest <= id_ex_dest;
      ex_mem_alu  <= alu_out;
      ex_mem_b    <= op_b;
      mem_wb_dest <= ex_mem_dest;
      mem_wb_alu  <= ex_mem_alu;
      mem_wb_lmd  <= Mem[ex_mem_alu[AW-1:0]];
    end
  end

  // NOTE: register file and memory are deliberately not reset so preloaded contents survive rst.
  always_ff @(posedge clk1) begin
    if (!rst && !HALTED) begin
      if (wb_we) Reg[mem_wb_dest] <= wb_value;
      if (ex_mem_kind == K_STORE) Mem[ex_mem_alu[AW-1:0]] <= ex_mem_b;
    end
  end
endmodule

// File: tb/tb_pipe_mips32.sv
// Program-level bench for pipe_mips32: loads programs through hierarchy, runs
// the core to HLT and compares registers/memory against a queue of expectations.
module tb_pipe_mips32;
  logic clk1 = 1'b0;
  logic rst  = 1'b1;

  pipe_mips32 #(.MEM_DEPTH(1024)) dut (.clk1(clk1), .rst(rst));

  always #5 clk1 = ~clk1;

  typedef struct {
    string       name;
    bit          is_mem;
    int          idx;
    logic [31:0] value;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          taken_cnt   = 0;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, MUL = 6'b000101;
  localparam logic [5:0] LW = 6'b001000, SW = 6'b001001, ADDI = 6'b001010, SUBI = 6'b001011;
  localparam logic [5:0] BNEQZ = 6'b001101;
  localparam logic [31:0] NOP = 32'h3c00_0000;
  localparam logic [31:0] HLT = 32'hfc00_0000;

  always @(negedge clk1) if (dut.TAKEN_BRANCH === 1'b1) taken_cnt++;

  function automatic logic [31:0] r_ins(logic [5:0] op, int rs, int rt, int rd);
    return {op, rs[4:0], rt[4:0], rd[4:0], 11'd0};
  endfunction

  function automatic logic [31:0] i_ins(logic [5:0] op, int rs, int rt, int imm);
    return {op, rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  task automatic load_prog();
    for (int i = 0; i < 64; i++) dut.Mem[i] = NOP;
    foreach (prog[i]) dut.Mem[i] = prog[i];
  endtask

  task automatic expect_reg(int idx, logic [31:0] value);
    exp_t e;
    e.name = $sformatf("R%0d", idx); e.is_mem = 1'b0; e.idx = idx; e.value = value;
    sb.push_back(e);
  endtask

  task automatic expect_mem(int idx, logic [31:0] value);
    exp_t e;
    e.name = $sformatf("Mem[%0d]", idx); e.is_mem = 1'b1; e.idx = idx; e.value = value;
    sb.push_back(e);
  endtask

  task automatic drain_scoreboard();
    exp_t        e;
    logic [31:0] got;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = e.is_mem ? dut.Mem[e.idx] : dut.Reg[e.idx];
      vectors++;
      if (got !== e.value) begin
        miscompares++;
        $display("FAIL %s: got %0d (0x%08h), expected %0d", e.name, got, got, e.value);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk1); #1;
    rst = 1'b0;
  endtask

  task automatic run_to_halt(input string tag, input int budget);
    int cycles = 0;
    while (dut.HALTED !== 1'b1 && cycles < budget) begin
      @(posedge clk1); #1;
      cycles++;
    end
    vectors++;
    if (dut.HALTED !== 1'b1) begin
      miscompares++;
      $display("FAIL %s halt: HALTED=%b after %0d cycles, expected 1", tag, dut.HALTED, cycles);
    end
  endtask

  task automatic build_factorial();
    prog = {};
    prog.push_back(i_ins(ADDI, 0, 10, 200));
    prog.push_back(i_ins(ADDI, 0, 2, 1));
    prog.push_back(i_ins(ADDI, 0, 21, 0));
    prog.push_back(i_ins(ADDI, 0, 22, 0));
    prog.push_back(i_ins(LW, 10, 3, 0));
    prog.push_back(i_ins(ADDI, 0, 23, 0));
    prog.push_back(r_ins(MUL, 2, 3, 2));     // 6: loop head
    prog.push_back(i_ins(SUBI, 3, 3, 1));
    prog.push_back(i_ins(BNEQZ, 3, 0, -3));  // back to 6
    prog.push_back(i_ins(ADDI, 21, 21, 1));  // shadow slots: count only on fall-through
    prog.push_back(i_ins(ADDI, 22, 22, 1));
    prog.push_back(i_ins(SW, 10, 2, -2));
    prog.push_back(HLT);
    load_prog();
    dut.Mem[200] = 32'd7;
    dut.Mem[198] = 32'd0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (dut.PC !== 32'd0) begin
      miscompares++; $display("FAIL reset PC: got %0d, expected 0", dut.PC);
    end
    vectors++;
    if (dut.HALTED !== 1'b0) begin
      miscompares++; $display("FAIL reset HALTED: got %b, expected 0", dut.HALTED);
    end
    vectors++;
    if (dut.TAKEN_BRANCH !== 1'b0) begin
      miscompares++; $display("FAIL reset TAKEN_BRANCH: got %b, expected 0", dut.TAKEN_BRANCH);
    end
  endtask

  task automatic test_program1();
    int halt_cyc = -1;
    for (int k = 0; k < 32; k++) dut.Reg[k] = k;
    prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
             32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
    load_prog();
    expect_reg(0, 0);  expect_reg(1, 10); expect_reg(2, 20); expect_reg(3, 25);
    expect_reg(4, 30); expect_reg(5, 55); expect_reg(15, 7);
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk1); #1;
      if (dut.HALTED === 1'b1 && halt_cyc < 0) halt_cyc = i;
    end
    vectors++;
    if (halt_cyc != 13) begin
      miscompares++; $display("FAIL prog1 halt cycle: got %0d, expected 13", halt_cyc);
    end
    drain_scoreboard();
  endtask

  task automatic test_back_to_back();
    prog = '{i_ins(ADDI, 0, 1, 5), r_ins(ADD, 1, 1, 2), r_ins(ADD, 2, 1, 3),
             r_ins(SUB, 3, 2, 6), HLT};
    load_prog();
    expect_reg(1, 5); expect_reg(2, 10); expect_reg(3, 15); expect_reg(6, 5);
    do_reset();
    run_to_halt("b2b", 50);
    drain_scoreboard();
  endtask

  task automatic test_memory();
    dut.Mem[100] = 32'd85;
    dut.Mem[101] = 32'd0;
    prog = '{i_ins(ADDI, 0, 4, 100), i_ins(LW, 4, 2, 0), NOP,
             i_ins(ADDI, 2, 3, 45), i_ins(SW, 4, 3, 1), HLT};
    load_prog();
    expect_reg(2, 85); expect_reg(3, 130); expect_mem(101, 130);
    do_reset();
    run_to_halt("memory", 50);
    drain_scoreboard();
  endtask

  task automatic test_branch_loop();
    int t0;
    build_factorial();
    expect_reg(2, 5040); expect_reg(3, 0); expect_reg(21, 1); expect_reg(22, 1);
    expect_mem(198, 5040);
    do_reset();
    t0 = taken_cnt;
    run_to_halt("loop", 300);
    vectors++;
    if (taken_cnt - t0 != 6) begin
      miscompares++; $display("FAIL loop taken count: got %0d, expected 6", taken_cnt - t0);
    end
    drain_scoreboard();
  endtask

  task automatic test_halt_isolation();
    dut.Mem[300] = 32'hdead_beef;
    prog = '{i_ins(ADDI, 0, 1, 77), HLT, i_ins(SW, 0, 1, 300), i_ins(ADDI, 0, 1, 5)};
    load_prog();
    expect_reg(1, 77); expect_mem(300, 32'hdead_beef);
    do_reset();
    run_to_halt("halt", 50);
    repeat (6) @(posedge clk1);
    #1;
    vectors++;
    if (dut.PC !== 32'd2) begin
      miscompares++; $display("FAIL halt PC frozen: got %0d, expected 2", dut.PC);
    end
    vectors++;
    if (dut.HALTED !== 1'b1) begin
      miscompares++; $display("FAIL halt sticky: got %b, expected 1", dut.HALTED);
    end
    drain_scoreboard();
  endtask

  task automatic test_reset_midrun();
    int waited = 0;
    build_factorial();
    do_reset();
    while (dut.TAKEN_BRANCH !== 1'b1 && waited < 100) begin
      @(posedge clk1); #1;
      waited++;
    end
    vectors++;
    if (dut.TAKEN_BRANCH !== 1'b1) begin
      miscompares++; $display("FAIL midrun branch wait: TAKEN_BRANCH=%b, expected 1", dut.TAKEN_BRANCH);
    end
    do_reset();
    vectors++;
    if (dut.PC !== 32'd0 || dut.HALTED !== 1'b0 || dut.TAKEN_BRANCH !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun reset: PC=%0d HALTED=%b TAKEN=%b, expected 0/0/0",
               dut.PC, dut.HALTED, dut.TAKEN_BRANCH);
    end
    vectors++;
    if (dut.Mem[198] !== 32'd0) begin
      miscompares++; $display("FAIL midrun early store: got %0d, expected 0", dut.Mem[198]);
    end
    expect_reg(2, 5040); expect_reg(21, 1); expect_mem(198, 5040);
    run_to_halt("midrun", 300);
    drain_scoreboard();
  endtask

  initial begin
    test_reset();
    test_program1();
    test_back_to_back();
    test_memory();
    test_branch_loop();
    test_halt_isolation();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
